input_snapshot: RTL and testbench

Frame-synchronous capture block for multi-player controller inputs. It sits between the `hps_io` input buses and the core CPU. On every vblank rising edge it latches per-player buttons, left analog stick and spinner position into a double-buffered register file, and derives new-press edges and per-player press counters. It presents a stable, tear-free snapshot through a registered read port.

---
 rtl/input_snapshot_pkg.sv | 35 +++
 rtl/input_snapshot_spinner.sv | 36 +++
 rtl/input_snapshot.sv | 174 +++++++++++++++++
 tb/tb_input_snapshot.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_snapshot_pkg.sv
// input_snapshot shared types: capture FSM states, read selects,
// per-player snapshot entry and the saturating counter helper.
package input_snapshot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_HELD    = 2'd0;
    localparam logic [1:0] SEL_PRESSED = 2'd1;
    localparam logic [1:0] SEL_ANALOG  = 2'd2;
    localparam logic [1:0] SEL_COUNT   = 2'd3;

    typedef struct packed {
        logic [31:0] held;
        logic [31:0] pressed;
        logic [15:0] analog;
        logic [15:0] spos;
        logic [15:0] press_count;
    } entry_t;

    function automatic logic [15:0] sat_inc(
        input logic [15:0] v,
        input logic [15:0] max,
        input logic        en
    );
        if (en && (v != max)) begin
            return v + 16'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/input_snapshot_spinner.sv
// One player's spinner: toggle-change detection and a 16-bit
// wrapping position accumulator fed by the signed delta.
module input_snapshot_spinner (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        toggle_i,
    input  logic [7:0]  delta_i,
    output logic [15:0] pos_o
);

    logic        prev_q;
    logic [15:0] pos_q;
    logic [15:0] pos_d;

    // Add the sign-extended delta whenever the toggle flips
    always_comb begin
        pos_d = pos_q;
        if (toggle_i != prev_q) begin
            pos_d = pos_q + {{8{delta_i[7]}}, delta_i};
        end
    end

    // Track the last toggle and hold the accumulated position
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            prev_q <= 1'b0;
            pos_q  <= 16'd0;
        end else begin
            prev_q <= toggle_i;
            pos_q  <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/input_snapshot.sv
// Frame-synchronous double-buffered controller input snapshot.
// Optional spinner accumulators: define INPUT_SNAPSHOT_SPINNER_EN.
module input_snapshot
    import input_snapshot_pkg::*;
#(
    parameter int PLAYERS = 6,
    parameter int BTN_W   = 32,
    parameter int CNT_W   = 8
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     vblank,
    input  logic                     freeze,
    input  logic [PLAYERS*BTN_W-1:0] joystick,
    input  logic [PLAYERS*16-1:0]    analog_l,
    input  logic [PLAYERS*16-1:0]    spinner,
    input  logic [2:0]               rd_player,
    input  logic [1:0]               rd_sel,
    output logic [31:0]              rd_data,
    output logic                     frame_stb,
    output logic                     busy
);

    localparam logic [15:0] CNT_MAX = 16'((32'd1 << CNT_W) - 32'd1);
    localparam logic [2:0]  LAST    = 3'(PLAYERS - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        vblank_d_q;
    logic        ptr_q;
    logic        frame_stb_q;
    logic [31:0] rd_data_q, rd_data_d;
    logic        vb_edge;

    entry_t      bank_q [2][PLAYERS];
    entry_t      front_e;
    entry_t      cap_e;
    entry_t      rd_e;
    logic [31:0] held_new;
    logic [31:0] pressed_new;
    logic [15:0] spos [PLAYERS];
    logic        unused_spin;

    assign unused_spin = ^spinner;

`ifdef INPUT_SNAPSHOT_SPINNER_EN
    for (genvar p = 0; p < PLAYERS; p++) begin : g_spin
        input_snapshot_spinner u_spin (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .toggle_i (spinner[p*16+8]),
            .delta_i  (spinner[p*16 +: 8]),
            .pos_o    (spos[p])
        );
    end
`else
    for (genvar p = 0; p < PLAYERS; p++) begin : g_nospin
        assign spos[p] = 16'd0;
    end
`endif

    assign vb_edge = vblank & ~vblank_d_q;

    // Build the back-bank entry for the player under capture
    always_comb begin
        front_e  = '0;
        cap_e    = '0;
        held_new = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            if (idx_q == 3'(p)) begin
                front_e                = bank_q[ptr_q][p];
                held_new[BTN_W-1:0]    = joystick[p*BTN_W +: BTN_W];
                cap_e.analog           = analog_l[p*16 +: 16];
                cap_e.spos             = spos[p];
            end
        end
        pressed_new       = held_new & ~front_e.held;
        cap_e.held        = held_new;
        cap_e.pressed     = pressed_new;
        cap_e.press_count = sat_inc(front_e.press_count, CNT_MAX,
                                    |pressed_new);
    end

    // Capture sequencing: walk the players, then commit the bank swap
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (vb_edge && !freeze) begin
                    state_d = ST_CAPTURE;
                    idx_d   = 3'd0;
                end
            end
            ST_CAPTURE: begin
                if (idx_q == LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM, edge detector, bank pointer and strobe registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            vblank_d_q  <= vblank;
            ptr_q       <= 1'b0;
            frame_stb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vblank_d_q  <= vblank;
            frame_stb_q <= (state_q == ST_COMMIT);
            if (state_q == ST_COMMIT) begin
                ptr_q <= ~ptr_q;
            end
        end
    end

    // Write the captured entry into the back bank
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < PLAYERS; p++) begin
                    bank_q[b][p] <= '0;
                end
            end
        end else if (state_q == ST_CAPTURE) begin
            for (int p = 0; p < PLAYERS; p++) begin
                if (idx_q == 3'(p)) begin
                    bank_q[~ptr_q][p] <= cap_e;
                end
            end
        end
    end

    // Select the requested word from the front bank
    always_comb begin
        rd_e      = '0;
        rd_data_d = 32'd0;
        for (int p = 0; p < PLAYERS; p++) begin
            if (rd_player == 3'(p)) begin
                rd_e = bank_q[ptr_q][p];
            end
        end
        case (rd_sel)
            SEL_HELD:    rd_data_d = rd_e.held;
            SEL_PRESSED: rd_data_d = rd_e.pressed;
            SEL_ANALOG:  rd_data_d = {16'd0, rd_e.analog};
            SEL_COUNT:   rd_data_d = {rd_e.press_count, rd_e.spos};
            default:     rd_data_d = 32'd0;
        endcase
    end

    // Registered read port
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_data_q <= 32'd0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign frame_stb = frame_stb_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_input_snapshot.sv
// Randomized self-checking bench for input_snapshot against a
// frame-level reference model (spinner expectations follow the macro).
module tb_input_snapshot;

    localparam int NP = 6;
    localparam int BW = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              vblank;
    logic              freeze;
    logic [NP*BW-1:0]  joystick;
    logic [NP*16-1:0]  analog_l;
    logic [NP*16-1:0]  spinner;
    logic [2:0]        rd_player;
    logic [1:0]        rd_sel;
    logic [31:0]       rd_data;
    logic              frame_stb;
    logic              busy;

    always #5 clk_sys = ~clk_sys;

    input_snapshot #(
        .PLAYERS (NP),
        .BTN_W   (BW),
        .CNT_W   (CW)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .vblank    (vblank),
        .freeze    (freeze),
        .joystick  (joystick),
        .analog_l  (analog_l),
        .spinner   (spinner),
        .rd_player (rd_player),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .frame_stb (frame_stb),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int stb_count = 0;

    always @(posedge clk_sys) begin
        if (frame_stb === 1'b1) stb_count++;
    end

    logic [31:0] joy_in [NP];
    logic [15:0] ana_in [NP];
    logic        tog_in [NP];
    logic [7:0]  dl_in  [NP];
    logic [15:0] acc    [NP];
    logic [31:0] m_held [NP];
    logic [31:0] m_pr   [NP];
    logic [15:0] m_an   [NP];
    logic [15:0] m_sp   [NP];
    int          m_cnt  [NP];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            joystick[p*BW +: BW] = joy_in[p];
            analog_l[p*16 +: 16] = ana_in[p];
            spinner[p*16 +: 16]  = {7'b0, tog_in[p], dl_in[p]};
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            m_held[p] = 0; m_pr[p] = 0; m_an[p] = 0;
            m_sp[p] = 0; m_cnt[p] = 0; acc[p] = 0;
        end
    endtask

    task automatic model_frame();
        logic [31:0] pr;
        for (int p = 0; p < NP; p++) begin
            pr = joy_in[p] & ~m_held[p];
            if (pr != 0 && m_cnt[p] < CMAX) m_cnt[p]++;
            m_held[p] = joy_in[p];
            m_pr[p]   = pr;
            m_an[p]   = ana_in[p];
`ifdef INPUT_SNAPSHOT_SPINNER_EN
            m_sp[p]   = acc[p];
`else
            m_sp[p]   = 16'd0;
`endif
        end
    endtask

    function automatic logic [31:0] exp_word(input int p, input int s);
        if (p >= NP) return 32'd0;
        if (s == 0) return m_held[p];
        if (s == 1) return m_pr[p];
        if (s == 2) return {16'd0, m_an[p]};
        return {16'(m_cnt[p]), m_sp[p]};
    endfunction

    task automatic read_chk(input int p, input int s);
        rd_player = 3'(p);
        rd_sel    = 2'(s);
        tick();
        check($sformatf("rd_p%0d_s%0d", p, s), rd_data, exp_word(p, s));
    endtask

    task automatic check_all();
        for (int p = 0; p < 8; p++)
            for (int s = 0; s < 4; s++)
                read_chk(p, s);
    endtask

    task automatic spin(input int p, input logic [7:0] d);
        tog_in[p] = ~tog_in[p];
        dl_in[p]  = d;
        drive();
        tick();
        acc[p] = acc[p] + {{8{d[7]}}, d};
    endtask

    task automatic run_frame();
        int cyc;
        drive();
        vblank = 1'b1;
        tick();
        check("busy_on", 32'(busy), 32'd1);
        cyc = 0;
        while (frame_stb !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        check("stb_latency", 32'(cyc), 32'(NP + 1));
        tick();
        check("stb_width", 32'(frame_stb), 32'd0);
        check("busy_off", 32'(busy), 32'd0);
        vblank = 1'b0;
        tick();
        model_frame();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        reset = 1'b1; vblank = 1'b0; freeze = 1'b0;
        rd_player = 3'd0; rd_sel = 2'd0;
        for (int p = 0; p < NP; p++) begin
            joy_in[p] = 0; ana_in[p] = 0; tog_in[p] = 0; dl_in[p] = 0;
        end
        model_clear();
        drive();
        repeat (3) tick();
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_stb", 32'(frame_stb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        check_all();
        repeat (20) tick();
        check("no_stb_idle", 32'(stb_count), 32'd0);

        joy_in[2] = 32'h0000_0011;
        run_frame();
        read_chk(2, 0);
        check("first_held", rd_data, 32'h11);
        read_chk(2, 1);
        check("first_pressed", rd_data, 32'h11);
        read_chk(2, 3);
        check("first_count", {16'd0, rd_data[31:16]}, 32'd1);
        run_frame();
        read_chk(2, 1);
        check("repeat_pressed", rd_data, 32'd0);
        read_chk(2, 3);
        check("repeat_count", {16'd0, rd_data[31:16]}, 32'd1);
        check_all();

        for (int f = 0; f < 10; f++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 2) != 0)
                    joy_in[p] = $urandom() & $urandom();
                ana_in[p] = 16'($urandom_range(0, 65535));
            end
            run_frame();
            check_all();
        end

        for (int f = 0; f < 40; f++) begin
            joy_in[0] = (f % 2 == 0) ? 32'd1 : 32'd0;
            run_frame();
            read_chk(0, 3);
        end
        check("sat_count", {16'd0, rd_data[31:16]}, 32'(CMAX));
        check_all();

        acc[1] = 0;
        for (int i = 0; i < 3; i++) spin(1, 8'h05);
        spin(1, 8'hFE);
        run_frame();
        read_chk(1, 3);
`ifdef INPUT_SNAPSHOT_SPINNER_EN
        check("spin_sum", {16'd0, rd_data[15:0]}, 32'h000D);
`else
        check("spin_sum", {16'd0, rd_data[15:0]}, 32'h0000);
`endif
        spin(1, 8'hF1);
        run_frame();
        read_chk(1, 3);
        spin(1, 8'h03);
        run_frame();
        read_chk(1, 3);
`ifdef INPUT_SNAPSHOT_SPINNER_EN
        check("spin_wrap", {16'd0, rd_data[15:0]}, 32'h0001);
`else
        check("spin_wrap", {16'd0, rd_data[15:0]}, 32'h0000);
`endif
        check_all();

        for (int p = 0; p < NP; p++) joy_in[p] = $urandom();
        drive();
        s0 = stb_count;
        freeze = 1'b1;
        vblank = 1'b1;
        repeat (15) tick();
        check("freeze_no_stb", 32'(stb_count), 32'(s0));
        check("freeze_idle", 32'(busy), 32'd0);
        vblank = 1'b0;
        freeze = 1'b0;
        tick();
        check_all();

        s0 = stb_count;
        vblank = 1'b1;
        tick();
        tick();
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        repeat (15) tick();
        check("double_edge_one_stb", 32'(stb_count), 32'(s0 + 1));
        model_frame();
        vblank = 1'b0;
        tick();
        check_all();

        for (int p = 0; p < NP; p++) joy_in[p] = $urandom() | 32'h1;
        drive();
        s0 = stb_count;
        vblank = 1'b1;
        tick();
        repeat (3) tick();
        reset = 1'b1;
        for (int p = 0; p < NP; p++) begin
            tog_in[p] = 1'b0;
            dl_in[p]  = 8'd0;
        end
        drive();
        tick();
        reset = 1'b0;
        model_clear();
        repeat (15) tick();
        check("midrst_no_stb", 32'(stb_count), 32'(s0));
        check("midrst_idle", 32'(busy), 32'd0);
        vblank = 1'b0;
        tick();
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
